// File: rtl/dmem_responder_if.sv
// Initiator/responder bus for the data-memory responder.
// The initiator drives the request fields; the responder drives the response strobe and data.
interface dmem_responder_if;
   logic        req;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        ready;
   logic        err;
   logic        busy;

   modport master (
      output req, mem_write, mem_read, address, writeData,
      input  readData, ready, err, busy
   );

   modport slave (
      input  req, mem_write, mem_read, address, writeData,
      output readData, ready, err, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed number of wait states before a one-cycle response.
// Misaligned, out-of-range or ambiguous (load+store / neither) requests get an error response.
module dmem_responder #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic             clock,
   input logic             rst,
   dmem_responder_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        wr_q;
   logic        rd_q;
   logic [31:0] rdata_q;
   logic        ready_q;
   logic        err_q;
   logic        busy_q;

   logic [31:0] mem_q [2**ADDR_W];

   logic [31:0]       addr_d;
   logic [31:0]       wdata_d;
   logic              wr_d;
   logic              rd_d;
   logic              err_d;
   logic              enter_resp_d;
   logic              store_d;
   logic [ADDR_W-1:0] idx_d;

   // With no wait states the response is entered on the accept edge, so the
   // live inputs stand in for the captured fields in IDLE.
   always_comb begin
      addr_d       = (state_q == S_IDLE) ? bus.address   : addr_q;
      wdata_d      = (state_q == S_IDLE) ? bus.writeData : wdata_q;
      wr_d         = (state_q == S_IDLE) ? bus.mem_write : wr_q;
      rd_d         = (state_q == S_IDLE) ? bus.mem_read  : rd_q;
      idx_d        = addr_d[ADDR_W+1:2];
      err_d        = (addr_d[1:0] != 2'b00) || ((addr_d >> (ADDR_W + 2)) != '0) || (wr_d == rd_d);
      enter_resp_d = ((state_q == S_IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == '0));
      store_d      = enter_resp_d && !err_d && wr_d && !rst;
   end

   // Storage has no reset so its contents survive rst.
   always_ff @(posedge clock) begin
      if (store_d) begin
         mem_q[idx_d] <= wdata_d;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ready_q <= enter_resp_d;
         err_q   <= enter_resp_d && err_d;
         if (enter_resp_d && !err_d && rd_d) begin
            rdata_q <= mem_q[idx_d];
         end
         case (state_q)
            S_IDLE: begin
               if (bus.req) begin
                  addr_q  <= bus.address;
                  wdata_q <= bus.writeData;
                  wr_q    <= bus.mem_write;
                  rd_q    <= bus.mem_read;
                  busy_q  <= 1'b1;
                  if (WAIT_CYCLES == 0) begin
                     state_q <= S_RESP;
                  end else begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_RESP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.readData = rdata_q;
   assign bus.ready    = ready_q;
   assign bus.err      = err_q;
   assign bus.busy     = busy_q;

endmodule
